// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the seven-segment scan driver
package seven_seg_pkg;
  typedef logic [6:0] seg_t;
  typedef logic [1:0] digit_idx_t;

  localparam seg_t       SEG_OFF   = 7'h7F;
  localparam logic [3:0] ANODE_OFF = 4'hF;

  typedef enum logic {SCAN_ON, SCAN_BLANK} scan_state_t;
endpackage

// File: rtl/hex_to_seg.sv
// rtl/hex_to_seg.sv - hex nibble to active-low {g,f,e,d,c,b,a} segment decode
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output seg_t       seg
);
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - 4-digit common-anode scan driver with per-frame snapshot
// Optional leading-zero blanking: SEVEN_SEG_LEADING_ZERO_BLANK_EN
module seven_seg_scan_driver
  import seven_seg_pkg::*;
#(
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] value,
  input  logic [3:0]  decimal_point,
  output logic [3:0]  anode,
  output seg_t        cathode,
  output logic        dp_n,
  output logic        frame_tick
);
  localparam int COUNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int PW        = $clog2(COUNT_MAX);
  localparam logic [PW-1:0] ON_LAST    = PW'(REFRESH_DIV - 1);
  localparam logic [PW-1:0] BLANK_LAST = PW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

  scan_state_t   state;
  digit_idx_t    idx;
  logic [PW-1:0] presc;
  logic [15:0]   snap_value;
  logic [3:0]    snap_dp;
  logic [3:0]    nibble;
  seg_t          digit_seg;
  logic          blank_digit;
  logic          last_phase;
  logic          advance;

  always_comb begin
    nibble     = snap_value[{idx, 2'b00} +: 4];
    last_phase = (state == SCAN_ON) ? (presc == ON_LAST) : (presc == BLANK_LAST);
    advance    = last_phase && ((state == SCAN_BLANK) || (BLANK_CYCLES == 0));
  end

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  // A digit is a leading zero only if it and every digit to its left are zero with DP off.
  logic lz3, lz2, lz1;
  assign lz3 = (snap_value[15:12] == 4'h0) && !snap_dp[3];
  assign lz2 = lz3 && (snap_value[11:8] == 4'h0) && !snap_dp[2];
  assign lz1 = lz2 && (snap_value[7:4] == 4'h0) && !snap_dp[1];
  assign blank_digit = (idx == 2'd3) ? lz3 :
                       (idx == 2'd2) ? lz2 :
                       (idx == 2'd1) ? lz1 : 1'b0;
`else
  assign blank_digit = 1'b0;
`endif

  hex_to_seg u_hex_to_seg (
    .nibble (nibble),
    .seg    (digit_seg)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= SCAN_ON;
      idx        <= '0;
      presc      <= '0;
      snap_value <= '0;
      snap_dp    <= '0;
      anode      <= ANODE_OFF;
      cathode    <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_tick <= 1'b0;
    end else begin
      frame_tick <= 1'b0;
      // Outputs are taken from the pre-edge state, so pins lag the scan by one cycle.
      if (state == SCAN_ON) begin
        anode   <= ~(4'b0001 << idx);
        cathode <= blank_digit ? SEG_OFF : digit_seg;
        dp_n    <= ~snap_dp[idx];
      end else begin
        anode   <= ANODE_OFF;
        cathode <= SEG_OFF;
        dp_n    <= 1'b1;
      end

      if (last_phase) begin
        presc <= '0;
        if ((state == SCAN_ON) && (BLANK_CYCLES > 0)) state <= SCAN_BLANK;
        else                                          state <= SCAN_ON;
      end else begin
        presc <= presc + PW'(1);
      end

      // The snapshot is only taken on the 3->0 wrap so a frame never mixes two words.
      if (advance) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_value <= value;
          snap_dp    <= decimal_point;
          frame_tick <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - self-checking bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;
  localparam int RD  = 4;
  localparam int BC0 = 2;
  localparam int BC1 = 0;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  localparam logic [6:0] LZ_SEG = 7'h7F;
`else
  localparam logic [6:0] LZ_SEG = 7'b1000000;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] val [2];
  logic [3:0]  dpv [2];
  logic [3:0]  an  [2];
  logic [6:0]  cat [2];
  logic        dpn [2];
  logic        ft  [2];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC0)) dut0 (
    .clk(clk), .reset_n(reset_n), .value(val[0]), .decimal_point(dpv[0]),
    .anode(an[0]), .cathode(cat[0]), .dp_n(dpn[0]), .frame_tick(ft[0]));

  seven_seg_scan_driver #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC1)) dut1 (
    .clk(clk), .reset_n(reset_n), .value(val[1]), .decimal_point(dpv[1]),
    .anode(an[1]), .cathode(cat[1]), .dp_n(dpn[1]), .frame_tick(ft[1]));

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: after n edges since release, the pins show scan step n-1. Step s lies in
  // slot s % (RD+BC) of digit (s / (RD+BC)) % 4; a new word is latched every frame edge.
  int          n     [2];
  logic [15:0] msnap [2];
  logic [3:0]  mdp   [2];
  logic [3:0]  e_an  [2];
  logic [6:0]  e_cat [2];
  logic        e_dpn [2];
  logic        e_ft  [2];

  always @(posedge clk or negedge reset_n) begin : model
    int per, slot, dig;
    logic blank;
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < 2; k++) begin
      if (!reset_n) begin
        n[k] = 0; msnap[k] = '0; mdp[k] = '0;
        e_an[k] = 4'hF; e_cat[k] = 7'h7F; e_dpn[k] = 1'b1; e_ft[k] = 1'b0;
      end else begin
        per  = RD + ((k == 0) ? BC0 : BC1);
        slot = n[k] % per;
        dig  = (n[k] / per) % 4;
        blank = 1'b0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
        blank = (dig != 0);
        for (int j = dig; j < 4; j++)
          if (msnap[k][j*4 +: 4] != 4'h0 || mdp[k][j]) blank = 1'b0;
`endif
        if (slot < RD) begin
          e_an[k]  = ~(one << dig);
          e_cat[k] = blank ? 7'h7F : SEG_TABLE[msnap[k][dig*4 +: 4]];
          e_dpn[k] = ~mdp[k][dig];
        end else begin
          e_an[k] = 4'hF; e_cat[k] = 7'h7F; e_dpn[k] = 1'b1;
        end
        n[k]++;
        e_ft[k] = (n[k] % (4 * per) == 0);
        if (e_ft[k]) begin
          msnap[k] = val[k];
          mdp[k]   = dpv[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      cmp($sformatf("model dut%0d anode", k), 16'(an[k]), 16'(e_an[k]));
      cmp($sformatf("model dut%0d cathode", k), 16'(cat[k]), 16'(e_cat[k]));
      cmp($sformatf("model dut%0d dp_n", k), 16'(dpn[k]), 16'(e_dpn[k]));
      cmp($sformatf("model dut%0d frame_tick", k), 16'(ft[k]), 16'(e_ft[k]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_tick(input int k, output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!ft[k] && cnt < 200);
    checks++;
    if (!ft[k]) begin
      errors++;
      $display("FAIL tick_timeout dut%0d: got no frame_tick within %0d cycles", k, cnt);
    end
  endtask

  task automatic pin(input string name, input int k, input logic [3:0] a, input logic [6:0] c, input logic d);
    cmp({name, " anode"}, 16'(an[k]), 16'(a));
    cmp({name, " cathode"}, 16'(cat[k]), 16'(c));
    cmp({name, " dp_n"}, 16'(dpn[k]), 16'(d));
  endtask

  initial begin
    int c;
    val[0] = 16'h1234; dpv[0] = 4'b0010;
    val[1] = 16'h8888; dpv[1] = 4'b0000;
    reset_n = 1'b0;
    repeat (3) step();
    for (int k = 0; k < 2; k++) begin
      pin("reset", k, 4'b1111, 7'h7F, 1'b1);
      cmp("reset frame_tick", 16'(ft[k]), 16'd0);
    end
    @(negedge clk); #2 reset_n = 1'b1;

    step();
    pin("pre-wrap digit0", 0, 4'b1110, 7'b1000000, 1'b1);
    wait_tick(0, c);
    cmp("first tick latency", 16'(c), 16'd23);
    step();
    pin("1234 d0", 0, 4'b1110, 7'b0011001, 1'b1);
    repeat (6) step();
    pin("1234 d1", 0, 4'b1101, 7'b0110000, 1'b0);
    repeat (6) step();
    pin("1234 d2", 0, 4'b1011, 7'b0100100, 1'b1);
    val[0] = 16'hABCD; dpv[0] = 4'b0000;
    repeat (6) step();
    pin("1234 d3 after change", 0, 4'b0111, 7'b1111001, 1'b1);
    repeat (6) step();
    pin("ABCD d0", 0, 4'b1110, 7'b0100001, 1'b1);

    val[0] = 16'h0042;
    wait_tick(0, c);
    cmp("tick interval", 16'(c), 16'd23);
    step();
    pin("0042 d0", 0, 4'b1110, 7'b0100100, 1'b1);
    repeat (6) step();
    pin("0042 d1", 0, 4'b1101, 7'b0011001, 1'b1);
    repeat (6) step();
    pin("0042 d2", 0, 4'b1011, LZ_SEG, 1'b1);
    dpv[0] = 4'b0100;
    repeat (6) step();
    pin("0042 d3", 0, 4'b0111, LZ_SEG, 1'b1);
    wait_tick(0, c);
    repeat (13) step();
    pin("0042 dp2 d2", 0, 4'b1011, 7'b1000000, 1'b0);
    repeat (6) step();
    pin("0042 dp2 d3", 0, 4'b0111, LZ_SEG, 1'b1);

    val[0] = 16'h0000; dpv[0] = 4'b0000;
    wait_tick(0, c);
    step();
    pin("0000 d0", 0, 4'b1110, 7'b1000000, 1'b1);
    repeat (6) step();
    pin("0000 d1", 0, 4'b1101, LZ_SEG, 1'b1);
    wait_tick(0, c);
    wait_tick(0, c);
    cmp("frame period blank2", 16'(c), 16'd24);

    wait_tick(1, c);
    wait_tick(1, c);
    cmp("frame period blank0", 16'(c), 16'd16);
    step();
    pin("8888 d0", 1, 4'b1110, 7'b0000000, 1'b1);

    c = 0;
    while (an[0] !== 4'b1011 && c < 100) begin
      step();
      c++;
    end
    cmp("reach digit2", 16'(an[0]), 16'(4'b1011));
    #2 reset_n = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      pin("async reset", k, 4'b1111, 7'h7F, 1'b1);
      cmp("async reset frame_tick", 16'(ft[k]), 16'd0);
    end
    repeat (2) step();
    @(negedge clk); #2 reset_n = 1'b1;
    step();
    pin("restart d0", 0, 4'b1110, 7'b1000000, 1'b1);
    pin("restart d0 b0", 1, 4'b1110, 7'b1000000, 1'b1);
    repeat (40) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
